// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
// Decodes PS/2 Set-2 scan-code bytes (E0 / F0 / E1 prefixes) into a held-key
// bitmap for the game controls and a show-ahead FIFO of make/break events.
// Optional build macro: SCANCODE_TYPEMATIC_FILTER_EN -- when defined, repeated
// makes of an already-held mapped key are not pushed into the event FIFO.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       evt_ready,
    input  logic       overflow_clr,
    output logic [4:0] keys_held,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_brk,
    output logic       overflow,
    output logic       busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

    // Key map: bit order W, S, UP, DOWN, SPACE; codes packed LSB-first.
    localparam logic [39:0] KEY_CODES = {8'h29, 8'h72, 8'h75, 8'h1B, 8'h1D};
    localparam logic [4:0]  KEY_EXTS  = 5'b01100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      skip_cnt_q, skip_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [4:0]      keys_held_q, keys_held_d;
    logic            overflow_q, overflow_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [9:0]      head_q, head_d;
    logic [9:0]      mem_q [FIFO_DEPTH];

    logic            is_prefix;
    logic            is_ignored;
    logic            timeout;
    logic            ev_fire;
    logic            ev_ext;
    logic            ev_brk;
    logic [4:0]      key_hit;
    logic            repeat_make;
    logic            push_req;
    logic            pop;
    logic            full;
    logic            push_ok;
    logic            drop;
    logic [9:0]      entry_new;

    // Byte classification shared by the FSM and the event decoder
    always_comb begin
        is_prefix  = (byte_in == 8'hE0) || (byte_in == 8'hF0) || (byte_in == 8'hE1);
        is_ignored = 1'b0;
        case (byte_in)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: is_ignored = 1'b1;
            default:                    is_ignored = 1'b0;
        endcase
    end

    // Abandon a partial sequence when no follow-up byte arrives in time
    always_comb begin
        timeout  = (state_q != ST_IDLE) && !byte_valid && (to_cnt_q == TO_LAST);
        to_cnt_d = to_cnt_q + TW'(1);
        if (byte_valid || state_q == ST_IDLE) begin
            to_cnt_d = '0;
        end
    end

    // FSM state register (with skip and timeout counters)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            skip_cnt_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    // FSM next-state logic: advance only on byte strobes, or fall back on timeout
    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        if (byte_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_in == 8'hE0) begin
                        state_d = ST_EXT;
                    end else if (byte_in == 8'hF0) begin
                        state_d = ST_BRK;
                    end else if (byte_in == 8'hE1) begin
                        state_d    = ST_SKIP;
                        skip_cnt_d = 3'd7;
                    end
                end
                ST_EXT: begin
                    if (byte_in == 8'hF0) begin
                        state_d = ST_EXT_BRK;
                    end else if (byte_in == 8'hE0 || byte_in == 8'hE1) begin
                        state_d = ST_EXT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK:     state_d = ST_IDLE;
                ST_EXT_BRK: state_d = ST_IDLE;
                ST_SKIP: begin
                    if (skip_cnt_q <= 3'd1) begin
                        state_d    = ST_IDLE;
                        skip_cnt_d = '0;
                    end else begin
                        skip_cnt_d = skip_cnt_q - 3'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout) begin
            state_d = ST_IDLE;
        end
    end

    // FSM output logic: which byte completes a make or break event
    always_comb begin
        ev_fire = 1'b0;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        if (byte_valid) begin
            case (state_q)
                ST_IDLE: begin
                    ev_fire = !is_prefix && !is_ignored;
                end
                ST_EXT: begin
                    ev_fire = !is_prefix && (byte_in != 8'h12);
                    ev_ext  = 1'b1;
                end
                ST_BRK: begin
                    ev_fire = !is_prefix;
                    ev_brk  = 1'b1;
                end
                ST_EXT_BRK: begin
                    ev_fire = !is_prefix && (byte_in != 8'h12);
                    ev_ext  = 1'b1;
                    ev_brk  = 1'b1;
                end
                default: ev_fire = 1'b0;
            endcase
        end
    end

    // Per-key match and held-bit update; ext flag must match the map entry
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_key
            always_comb begin
                key_hit[gi]     = ev_fire && (byte_in == KEY_CODES[gi*8 +: 8])
                                  && (ev_ext == KEY_EXTS[gi]);
                keys_held_d[gi] = key_hit[gi] ? !ev_brk : keys_held_q[gi];
            end
        end
    endgenerate

    // Decide whether the decoded event enters the FIFO
    always_comb begin
        repeat_make = !ev_brk && |(key_hit & keys_held_q);
`ifdef SCANCODE_TYPEMATIC_FILTER_EN
        push_req    = ev_fire && !repeat_make;
`else
        push_req    = ev_fire;
`endif
        entry_new   = {ev_ext, ev_brk, byte_in};
    end

    // FIFO pointer/count bookkeeping, show-ahead head selection and overflow
    always_comb begin
        pop      = (count_q != '0) && evt_ready;
        full     = (count_q == FULL_CNT);
        push_ok  = push_req && (!full || pop);
        drop     = push_req && full && !pop;

        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CW'(1);
        end

        // The head holds its last value when the FIFO drains.
        head_d = head_q;
        if (count_d != '0) begin
            if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
                head_d = entry_new;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end

        // A new drop wins over a simultaneous clear.
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    // FIFO storage; contents are only observed through the registered head
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= entry_new;
        end
    end

    // Key bitmap, FIFO control and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keys_held_q <= '0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_q      <= '0;
        end else begin
            keys_held_q <= keys_held_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_q      <= head_d;
        end
    end

    assign keys_held = keys_held_q;
    assign evt_valid = (count_q != '0);
    assign evt_ext   = head_q[9];
    assign evt_brk   = head_q[8];
    assign evt_code  = head_q[7:0];
    assign overflow  = overflow_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
